// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl - data-memory controller between the core's data port and a
// synchronous single-port word RAM with byte enables.
//
// A request (MREQ/WRITE/SIZE/DAD/DDT) is accepted in IDLE. Aligned requests
// perform one RAM cycle, optionally after WAIT_CYCLES wait states. Misaligned
// requests are acknowledged immediately with misalign_err. Completion is a
// one-cycle low pulse on ACKD_n. Load data is returned right-justified and
// zero-extended on DDT during that pulse. Lanes are big-endian.
//
// Build option:
//   DMEM_WAIT_EN  defined   -> WAIT state and wait counter present; WAIT_CYCLES honoured
//                 undefined -> no WAIT state; WAIT_CYCLES ignored (latency as 0)
//
// Parameters:
//   ADDR_W       RAM word-address width (ram_addr = DAD[ADDR_W+1:2])
//   WAIT_CYCLES  wait states inserted before the RAM access (0..15)
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   DAD           byte address from the core
//   MREQ          request valid (sampled in IDLE)
//   WRITE         1 = store, 0 = load
//   SIZE          00 byte, 01 halfword, 10 word, 11 illegal
//   DDT           bidirectional data: store data in, load data out during ACK
//   ACKD_n        active-low completion pulse
//   misalign_err  high together with ACKD_n for a rejected request
//   ram_en/we     RAM enable / write strobe
//   ram_be        byte enables, bit 3 = bits [31:24]
//   ram_addr      RAM word address
//   ram_wdata     lane-replicated store data
//   ram_rdata     RAM read data, valid the cycle after ram_en
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       DAD,
    input  logic              MREQ,
    input  logic              WRITE,
    input  logic [1:0]        SIZE,
    inout  wire  [31:0]       DDT,
    output logic              ACKD_n,
    output logic              misalign_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
`ifdef DMEM_WAIT_EN
        ST_WAIT    = 3'd1,
`endif
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    // Halfword needs a[0]=0, word needs a[1:0]=00, size 11 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Big-endian byte enables: byte offset 0 is bits [31:24].
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b00: begin
                case (a)
                    2'b00:   be = 4'b1000;
                    2'b01:   be = 4'b0100;
                    2'b10:   be = 4'b0010;
                    2'b11:   be = 4'b0001;
                    default: be = 4'b0000;
                endcase
            end
            2'b01:   be = a[1] ? 4'b0011 : 4'b1100;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data over every lane so the byte enables alone select it.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pull the addressed lane down to bit 0, zero-extended.
    function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00: begin
                case (a)
                    2'b00:   r = {24'd0, d[31:24]};
                    2'b01:   r = {24'd0, d[23:16]};
                    2'b10:   r = {24'd0, d[15:8]};
                    2'b11:   r = {24'd0, d[7:0]};
                    default: r = 32'd0;
                endcase
            end
            2'b01:   r = a[1] ? {16'd0, d[15:0]} : {16'd0, d[31:16]};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [ADDR_W+1:0]   req_addr_r;
    logic [1:0]          req_size_r;
    logic                req_write_r;
    logic [31:0]         req_wdata_r;
    logic [ADDR_W+1:0]   cur_addr_s;
    logic [1:0]          cur_size_s;
    logic                cur_write_s;
    logic [31:0]         cur_wdata_s;
    logic [31:0]         result_r;
    logic                ddt_oe_r;
    logic                unused_s;

`ifdef DMEM_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    logic [3:0]          wait_cnt_r;
    assign unused_s = ^DAD[31:ADDR_W+2];
`else
    assign unused_s = ^{DAD[31:ADDR_W+2], (WAIT_CYCLES > 0)};
`endif

    // Request fields: live bus in IDLE (zero-wait path), latched copy afterwards.
    always_comb begin
        cur_addr_s  = req_addr_r;
        cur_size_s  = req_size_r;
        cur_write_s = req_write_r;
        cur_wdata_s = req_wdata_r;
        if (state_r == ST_IDLE) begin
            cur_addr_s  = DAD[ADDR_W+1:0];
            cur_size_s  = SIZE;
            cur_write_s = WRITE;
            cur_wdata_s = DDT;
        end else begin
            cur_addr_s  = req_addr_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (MREQ) begin
                    if (is_misaligned(SIZE, DAD[1:0])) begin
                        next_state_s = ST_ACK;
`ifdef DMEM_WAIT_EN
                    end else if (WAIT_CYCLES > 0) begin
                        next_state_s = ST_WAIT;
`endif
                    end else begin
                        next_state_s = ST_ACCESS;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
`ifdef DMEM_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
`endif
            ST_ACCESS: begin
                if (req_write_r) begin
                    next_state_s = ST_ACK;
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: next_state_s = ST_ACK;
            ST_ACK:     next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

`ifdef DMEM_WAIT_EN
    // Wait-state counter: loaded on acceptance, counts down to zero in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
        end else if (state_r == ST_IDLE && next_state_s == ST_WAIT) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if (state_r == ST_WAIT && wait_cnt_r != 4'd0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end
`endif

    // State register, request latch and all registered outputs. Outputs are
    // computed from next_state_s so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_addr_r   <= '0;
            req_size_r   <= 2'b00;
            req_write_r  <= 1'b0;
            req_wdata_r  <= 32'd0;
            result_r     <= 32'd0;
            ddt_oe_r     <= 1'b0;
            ACKD_n       <= 1'b1;
            misalign_err <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_be       <= 4'b0000;
            ram_addr     <= '0;
            ram_wdata    <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_IDLE && MREQ) begin
                req_addr_r  <= DAD[ADDR_W+1:0];
                req_size_r  <= SIZE;
                req_write_r <= WRITE;
                req_wdata_r <= DDT;
            end
            // RAM address/lanes are only updated on entry to ACCESS, so they
            // hold steady through ACCESS and ACK.
            if (next_state_s == ST_ACCESS) begin
                ram_en    <= 1'b1;
                ram_we    <= cur_write_s;
                ram_be    <= lane_be(cur_size_s, cur_addr_s[1:0]);
                ram_addr  <= cur_addr_s[ADDR_W+1:2];
                ram_wdata <= lane_wdata(cur_size_s, cur_wdata_s);
            end else begin
                ram_en    <= 1'b0;
                ram_we    <= 1'b0;
            end
            // Result is cleared in IDLE so a rejected load returns zero.
            if (state_r == ST_CAPTURE) begin
                result_r <= lane_extract(req_size_r, req_addr_r[1:0], ram_rdata);
            end else if (state_r == ST_IDLE) begin
                result_r <= 32'd0;
            end
            ACKD_n       <= (next_state_s != ST_ACK);
            // Only the misaligned path reaches ACK straight from IDLE.
            misalign_err <= (next_state_s == ST_ACK) && (state_r == ST_IDLE);
            ddt_oe_r     <= (next_state_s == ST_ACK) && !cur_write_s;
        end
    end

    assign DDT = ddt_oe_r ? result_r : {32{1'bz}};

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller directly downstream of the pipeline core's data port. Accepts MREQ/WRITE/SIZE/DAD/DDT requests from the MEM stage and performs them on a synchronous single-port word RAM with byte enables. Returns ACKD_n and, for reads, right-justified data on DDT. Supports configurable wait states.

## Interface
- ADDR_W, 10: RAM word-address width; ram_addr = DAD[ADDR_W+1:2], upper DAD bits ignored (aliasing).
- WAIT_CYCLES, 2: wait states inserted before the RAM access (0–15).
- clk  input  1  clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- DAD  input  32  byte address from core.
- MREQ  input  1  request valid, sampled in IDLE.
- WRITE  input  1  1 = store, 0 = load.
- SIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- DDT  inout  32  store data (core drives, right-justified) / load data (controller drives in ACK only).
- ACKD_n  output  1  active-low completion, one-cycle pulse.
- misalign_err  output  1  high with ACKD_n for a rejected request.
- ram_en, ram_we  output  1  RAM enable / write strobe.
- ram_be  output  4  byte enables; bit 3 = bits[31:24].
- ram_addr  output  ADDR_W  word address.
- ram_wdata  output  32  lane-replicated store data.
- ram_rdata  input  32  RAM read data, valid the cycle after ram_en.

## Operation
- States: IDLE, WAIT, ACCESS, CAPTURE, ACK.
- IDLE: on MREQ=1, latch DAD, SIZE, WRITE, DDT. If misaligned → ACK with error; else → WAIT (WAIT_CYCLES>0, counter loaded WAIT_CYCLES-1) or ACCESS.
- WAIT: decrement; at 0 → ACCESS.
- ACCESS: ram_en=1, ram_we=WRITE. Write → ACK; read → CAPTURE.
- CAPTURE: register ram_rdata, then lane-extract; → ACK.
- ACK: ACKD_n=0 for exactly one cycle; on a read, DDT driven with the result; → IDLE.
- Lanes are big-endian. For a byte, offset 0 → be 1000 … 3 → 0001, wdata = {4{d[7:0]}}. For a halfword, a[1]=0 → 1100, a[1]=1 → 0011, wdata = {2{d[15:0]}}. For a word, be = 1111.
- Load result is right-justified and zero-extended; sign extension is done by the core.
- Misaligned means halfword with a[0]=1, word with a[1:0]≠0, or SIZE=11. No RAM cycle is issued; misalign_err=1 during ACK; DDT=0 on a read.
- MREQ still high in the IDLE cycle after ACK is treated as a new request.
- DDT is high-Z except in ACK on reads.

## Timing
- Reset values: state IDLE, ACKD_n=1, misalign_err=0, ram_en=ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0, DDT=Z, counter=0.
- The request is sampled at cycle 0. W=WAIT_CYCLES.
  - Write: ACCESS at cycle 1+W, ACKD_n low at cycle 2+W.
  - Read: ACKD_n low at cycle 3+W.
  - Misaligned: ACKD_n low at cycle 1.
- rst in any state returns to IDLE at the next edge. A write not yet in ACCESS is never performed, and no ACK is issued for the aborted request.
- ram_be, ram_addr and ram_wdata are registered and stable from ACCESS through ACK.

## Configuration
- DMEM_WAIT_EN defined: WAIT state and counter present; WAIT_CYCLES honoured.
- DMEM_WAIT_EN undefined: WAIT state and counter removed, WAIT_CYCLES ignored; latency as W=0 (write ACK cycle 2, read ACK cycle 3).

## Test plan
- Word write 0xDEADBEEF to 0x10, W=2: ram_addr=4, ram_be=1111 at cycle 3, ACKD_n low at cycle 4. Word read of 0x10: DDT=0xDEADBEEF with ACKD_n low at cycle 5.
- Byte write 0xAB to 0x13: ram_be=0001, ram_wdata=0xABABABAB. Word read of 0x10 → 0xDEADBEAB.
- Halfword read at 0x12 → DDT=0x0000BEAB. Byte read at 0x10 → 0x000000DE.
- Word read at 0x11: ACKD_n and misalign_err high/low-pulse at cycle 1, DDT=0, ram_en never asserted.
- rst asserted during WAIT of a write to 0x20: no ram_we, ACKD_n stays 1. A following read of 0x20 returns the old contents.
- MREQ held high across ACK with a new DAD: second request starts in the next IDLE cycle and completes with normal latency.
